vc_fifo: RTL
============

Name: vc_fifo

Overview:
- Parametrised successor to the single-queue switch FIFO: a flit-aware input buffer holding NVC independent virtual-channel queues in one block.
- Sits at each switch input port, between link receiver and route/arbitration logic.
- Adds, beyond the single-queue FIFO: per-VC queues, null-flit filtering, packet-level occupancy (complete packets held), almost-full back-pressure, and sticky overflow/underflow flags.

Parameters:
- DATAW, 8, payload bits per flit; flit width FLITW = DATAW+2.
- DEPTH, 4, flits per VC queue; power of two, >= 2.
- NVC, 2, number of virtual channels; >= 2.
- AFULL_TH, DEPTH-1, per-VC occupancy at or above which afull[v] asserts.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write request.
- wvc  in  VCW  target VC of write; VCW = $clog2(NVC).
- pkti  in  FLITW  input flit, [FLITW-1:FLITW-2] = type (00 null, 10 head, 01 body, 11 tail), [DATAW-1:0] = payload.
- re  in  1  read (pop) request.
- rvc  in  VCW  VC selected for read.
- pkto  out  FLITW  head flit of queue rvc (first-word fall-through); null (all zero) when that queue is empty.
- empty  out  NVC  per-VC empty.
- full  out  NVC  per-VC full.
- afull  out  NVC  per-VC occupancy >= AFULL_TH.
- pkt_avail  out  NVC  queue holds at least one complete packet (tail stored).
- ovf  out  1  sticky: write dropped because target full.
- udf  out  1  sticky: read issued to an empty queue.

Behaviour:
- Reset (rst=1 at clock edge): all pointers, occupancy and packet counters cleared.
  - After reset: empty = all 1; full = afull = pkt_avail = 0; ovf = udf = 0; pkto = 0.
  - Reset mid-packet discards all stored flits; no partial-packet state survives.
- Queues: per-VC circular buffer.
  - Read/write pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - empty when pointers are equal; full when indices are equal and wrap bits differ.
  - Index wraps DEPTH-1 -> 0 with no gap.
- Write: we=1 and type != 00 -> flit stored at tail of queue wvc.
  - A null flit with we=1 is ignored: no storage, no flag.
- Write to a full queue: dropped and ovf set.
  - Exception: re=1 with rvc==wvc in the same cycle. The pop and the push both occur; occupancy stays DEPTH; no ovf.
- Read: pkto is combinational from the head of queue rvc.
  - re=1 with the queue non-empty pops that flit at the clock edge.
  - re=1 with the queue empty: no state change, udf set, pkto = 0.
- Latency: a flit written at edge N is visible on pkto (if it is the head of rvc) after edge N; i.e. 1-cycle write-to-read.
- Simultaneous events:
  - Write and read on different VCs are fully independent.
  - Write and read on the same non-empty VC: occupancy unchanged.
  - Write to an empty VC with a read of the same VC: the read is an underflow. The write still succeeds; no bypass.
- Packet counter per VC, width $clog2(DEPTH+1):
  - +1 when a tail is stored; -1 when a tail is popped; unchanged when both happen in the same cycle.
  - pkt_avail[v] = (count != 0).
- afull, empty, full and pkt_avail are derived from registered state only (no combinational path from we/re).
- ovf/udf stay set until rst; they are not cleared by subsequent good traffic.
- No checking of head/body/tail ordering; flits are stored as presented.

Decomposition:
- Shared package sw_pkg:
  - FLITW/DATAW defaults.
  - flit_type_t enum (FT_NULL=2'b00, FT_BODY=2'b01, FT_HEAD=2'b10, FT_TAIL=2'b11).
  - Type-field extract helper and NULL_FLIT constant.
- One sub-module, vc_queue: single-VC circular buffer with push/pop, empty/full/count, and tail counter.
  - vc_fifo instantiates NVC copies via generate.
  - vc_fifo adds write/read demux, pkto mux, afull compare and the sticky flags.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles -> empty=2'b11, full=0, afull=0, pkt_avail=0, ovf=udf=0, pkto=10'h000.
- Null filtering and ordering: on VC0 write head 10'b10_00000011, null, body 10'b01_00000000, tail 10'b11_00000000. Then -> 3 flits stored, pkt_avail[0]=1, afull[0]=1 (3 >= TH=3). Popping 3 times yields head, body, tail in order; then empty[0]=1, pkt_avail[0]=0.
- Full/overflow: write 4 body flits to VC1, then a 5th with re=0 -> full[1]=1, the 5th is dropped, ovf=1. Popping 4 returns payloads 0..3.
- Full with concurrent pop: VC1 full, we=1 and re=1 with rvc=wvc=1, payload 8'h55 -> no ovf, occupancy stays 4, 8'h55 appears last after draining.
- Independence and underflow: write head to VC0 while reading empty VC1 -> udf=1, pkto=0 during the read, VC0 occupancy 1, empty=2'b10.
- Reset mid-packet: store head and body on VC0, assert rst for one cycle -> all queues empty, ovf/udf cleared, pkto=0 on the next cycle.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared switch definitions: flit type encoding, default widths and flit helpers.
// Used by the switch input buffers and anything else that decodes flits.
package sw_pkg;

  localparam int DATAW_DEF = 8;
  localparam int FLITW_DEF = DATAW_DEF + 2;

  typedef enum logic [1:0] {
    FT_NULL = 2'b00,
    FT_BODY = 2'b01,
    FT_HEAD = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_t;

  localparam logic [FLITW_DEF-1:0] NULL_FLIT = '0;

  // Takes the two type bits of a flit of any width and returns them as an enum.
  function automatic flit_type_t flit_type(input logic [1:0] type_bits);
    return flit_type_t'(type_bits);
  endfunction

endpackage

// File: rtl/vc_queue.sv
// Single virtual-channel circular flit buffer with first-word fall-through head,
// occupancy output and a count of complete packets (stored tail flits).
module vc_queue
  import sw_pkg::*;
#(
  parameter int FLITW = FLITW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [FLITW-1:0]           flit_i,
  output logic [FLITW-1:0]           head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH+1)-1:0] tails_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [FLITW-1:0] mem_q [DEPTH];
  logic [AW:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    tcnt_q, tcnt_d;
  logic             do_push, do_pop, tail_in, tail_out;

  // Pointers carry an extra wrap bit so equal indices can mean full or empty.
  assign empty_o = (rd_q == wr_q);
  assign full_o  = (rd_q[AW-1:0] == wr_q[AW-1:0]) && (rd_q[AW] != wr_q[AW]);
  assign count_o = wr_q - rd_q;
  assign tails_o = tcnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // A full queue still accepts a push when the same cycle frees a slot.
  assign do_pop   = pop_i & ~empty_o;
  assign do_push  = push_i & (~full_o | do_pop);
  assign tail_in  = do_push && (flit_type(flit_i[FLITW-1 -: 2]) == FT_TAIL);
  assign tail_out = do_pop && (flit_type(head_o[FLITW-1 -: 2]) == FT_TAIL);

  always_comb begin
    rd_d   = rd_q + {{AW{1'b0}}, do_pop};
    wr_d   = wr_q + {{AW{1'b0}}, do_push};
    tcnt_d = tcnt_q;
    case ({tail_in, tail_out})
      2'b10:   tcnt_d = tcnt_q + CW'(1);
      2'b01:   tcnt_d = tcnt_q - CW'(1);
      default: tcnt_d = tcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      tcnt_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      tcnt_q <= tcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_q[AW-1:0]] <= flit_i;
    end
  end

endmodule

// File: rtl/vc_fifo.sv
// Switch input buffer: NVC independent flit queues sharing one write and one read port,
// with null-flit filtering, almost-full back-pressure and sticky overflow/underflow flags.
module vc_fifo
  import sw_pkg::*;
#(
  parameter int DATAW    = DATAW_DEF,
  parameter int DEPTH    = 4,
  parameter int NVC      = 2,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [$clog2(NVC)-1:0] wvc,
  input  logic [DATAW+1:0]       pkti,
  input  logic                   re,
  input  logic [$clog2(NVC)-1:0] rvc,
  output logic [DATAW+1:0]       pkto,
  output logic [NVC-1:0]         empty,
  output logic [NVC-1:0]         full,
  output logic [NVC-1:0]         afull,
  output logic [NVC-1:0]         pkt_avail,
  output logic                   ovf,
  output logic                   udf
);

  localparam int FLITW = DATAW + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [FLITW-1:0] head  [NVC];
  logic [AW:0]      count [NVC];
  logic [CW-1:0]    tails [NVC];
  logic [NVC-1:0]   push_v, pop_v, ovf_ev;
  logic             wr_null, rvc_ok;
  logic             ovf_q, ovf_d, udf_q, udf_d;

  assign wr_null = (flit_type(pkti[FLITW-1 -: 2]) == FT_NULL);
  assign rvc_ok  = (int'(rvc) < NVC);

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    assign push_v[v] = we && !wr_null && (int'(wvc) == v);
    assign pop_v[v]  = re && (int'(rvc) == v);

    vc_queue #(
      .FLITW (FLITW),
      .DEPTH (DEPTH)
    ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_v[v]),
      .pop_i   (pop_v[v]),
      .flit_i  (pkti),
      .head_o  (head[v]),
      .empty_o (empty[v]),
      .full_o  (full[v]),
      .count_o (count[v]),
      .tails_o (tails[v])
    );

    assign afull[v]     = (int'(count[v]) >= AFULL_TH);
    assign pkt_avail[v] = (tails[v] != '0);
    // Full queue only drops the write when no pop on the same VC makes room.
    assign ovf_ev[v]    = push_v[v] && full[v] && !pop_v[v];
  end

  assign pkto = rvc_ok ? head[rvc] : '0;

  always_comb begin
    ovf_d = ovf_q | (|ovf_ev);
    udf_d = udf_q | (re && (!rvc_ok || empty[rvc]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule
